// File: rtl/rx_pkg.sv
// Shared constants and state encoding for the RX frame checker.
package rx_pkg;

  localparam int DATA_W    = 8;
  localparam int DLY_DEPTH = 4;

  // Reflected CRC-32 (Ethernet FCS)
  localparam logic [31:0] CRC_POLY    = 32'hEDB8_8320;
  localparam logic [31:0] CRC_INIT    = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB_20E3;

  // Frame length limits, byte counts including FCS
  localparam logic [10:0] MIN_FRAME = 11'd64;
  localparam logic [10:0] MAX_FRAME = 11'd1518;
  localparam logic [10:0] LEN_SAT   = 11'd2047;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FILL   = 2'd1,
    ST_STREAM = 2'd2,
    ST_STATUS = 2'd3
  } rx_state_t;

endpackage

// File: rtl/crc32_d8.sv
// One byte step of the reflected CRC-32, LSB of the data byte first.
module crc32_d8
  import rx_pkg::*;
(
  input  logic [31:0]       crc_in,
  input  logic [DATA_W-1:0] data,
  output logic [31:0]       crc_out
);

  // Eight serial shift/XOR steps unrolled into one combinational cloud
  always_comb begin
    logic [31:0] c;
    c = crc_in ^ {24'h0, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
    end
    crc_out = c;
  end

endmodule

// File: rtl/my_bin2gray.sv
// Binary to reflected-binary Gray code conversion.
module my_bin2gray #(
  parameter int W = 16
) (
  input  logic [W-1:0] bin,
  output logic [W-1:0] gray
);

  assign gray = bin ^ (bin >> 1);

endmodule

// File: rtl/rx_frame_checker.sv
// Pops bytes from an FWFT RX FIFO, strips the 4-byte FCS through a delay
// line, checks CRC-32 and length, and reports per-frame status and counters.
module rx_frame_checker
  import rx_pkg::*;
(
  input  logic              clk,
  input  logic              arst_n,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_dout,
  input  logic              fifo_EOD_out,
  output logic              fifo_rden,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_last,
  output logic              frm_done,
  output logic              frm_ok,
  output logic              frm_runt,
  output logic              frm_long,
  output logic [10:0]       frm_len,
  output logic [15:0]       good_count_gray,
  output logic [15:0]       bad_count_gray
);

  rx_state_t         state_q, state_d;
  logic [DATA_W-1:0] dly_p0 [DLY_DEPTH];
  logic [DATA_W-1:0] data_p1;
  logic              vld_p1, last_p1;
  logic [1:0]        fill_cnt_q;
  logic [10:0]       len_q;
  logic [31:0]       crc_q, crc_next;
  logic [15:0]       good_cnt_q, bad_cnt_q;
  logic              pop, frame_start, len_runt, len_long, crc_good;

  crc32_d8 u_crc (
    .crc_in  (crc_q),
    .data    (fifo_dout),
    .crc_out (crc_next)
  );

  // STATUS doubles as the start-of-frame slot so back-to-back frames lose one cycle only
  assign frame_start = (state_q == ST_IDLE) || (state_q == ST_STATUS);
  assign len_runt    = len_q < MIN_FRAME;
  assign len_long    = len_q > MAX_FRAME;
  assign crc_good    = crc_q == CRC_RESIDUE;

  // State register
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // Next state, FIFO pop and status strobes
  always_comb begin
    state_d  = state_q;
    pop      = 1'b0;
    frm_done = 1'b0;
    frm_ok   = 1'b0;
    frm_runt = 1'b0;
    frm_long = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) state_d = ST_FILL;
      end
      ST_FILL: begin
        if (!fifo_empty) begin
          pop = 1'b1;
          if (fifo_EOD_out)            state_d = ST_STATUS;
          else if (fill_cnt_q == 2'd3) state_d = ST_STREAM;
        end
      end
      ST_STREAM: begin
        // Stop popping once the final byte sits in the output register
        pop = !fifo_empty && !(vld_p1 && last_p1) && (!vld_p1 || m_ready);
        if (vld_p1 && last_p1 && m_ready) state_d = ST_STATUS;
      end
      ST_STATUS: begin
        frm_done = 1'b1;
        frm_runt = len_runt;
        frm_long = len_long;
        frm_ok   = crc_good && !len_runt && !len_long;
        state_d  = fifo_empty ? ST_IDLE : ST_FILL;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign fifo_rden = pop;

  // Four-byte delay line holding back the trailing FCS
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      for (int i = 0; i < DLY_DEPTH; i++) dly_p0[i] <= '0;
    end else if (pop) begin
      dly_p0[0] <= fifo_dout;
      for (int i = 1; i < DLY_DEPTH; i++) dly_p0[i] <= dly_p0[i-1];
    end
  end

  // Output data register, loaded with the oldest delay-line byte
  always_ff @(posedge clk) begin
    if (pop && (state_q == ST_STREAM)) data_p1 <= dly_p0[DLY_DEPTH-1];
  end

  // Output valid/last, held until the byte is accepted
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      vld_p1  <= 1'b0;
      last_p1 <= 1'b0;
    end else if (pop && (state_q == ST_STREAM)) begin
      vld_p1  <= 1'b1;
      last_p1 <= fifo_EOD_out;
    end else if (m_ready) begin
      vld_p1  <= 1'b0;
      last_p1 <= 1'b0;
    end
  end

  // Per-frame fill count, saturating length and running CRC
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      fill_cnt_q <= 2'd0;
      len_q      <= 11'd0;
      crc_q      <= 32'd0;
    end else if (frame_start) begin
      fill_cnt_q <= 2'd0;
      len_q      <= 11'd0;
      crc_q      <= CRC_INIT;
    end else if (pop) begin
      if (state_q == ST_FILL) fill_cnt_q <= fill_cnt_q + 2'd1;
      if (len_q != LEN_SAT)   len_q      <= len_q + 11'd1;
      crc_q <= crc_next;
    end
  end

  // Good/bad frame counters, wrapping modulo 2^16
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      good_cnt_q <= 16'd0;
      bad_cnt_q  <= 16'd0;
    end else if (state_q == ST_STATUS) begin
      if (frm_ok) good_cnt_q <= good_cnt_q + 16'd1;
      else        bad_cnt_q  <= bad_cnt_q + 16'd1;
    end
  end

  my_bin2gray #(.W(16)) u_good_gray (.bin(good_cnt_q), .gray(good_count_gray));
  my_bin2gray #(.W(16)) u_bad_gray  (.bin(bad_cnt_q),  .gray(bad_count_gray));

  assign m_data  = data_p1;
  assign m_valid = vld_p1;
  assign m_last  = last_p1;
  assign frm_len = len_q;

endmodule

// File: tb/tb_rx_frame_checker.sv
// Directed bench for rx_frame_checker: FWFT FIFO model, output sink with
// scheduled back-pressure, and hand-derived per-frame expectations.
module tb_rx_frame_checker;

  logic        clk = 1'b0;
  logic        arst_n;
  logic        fifo_empty;
  logic [7:0]  fifo_dout;
  logic        fifo_EOD_out;
  logic        fifo_rden;
  logic [7:0]  m_data;
  logic        m_valid;
  logic        m_ready;
  logic        m_last;
  logic        frm_done, frm_ok, frm_runt, frm_long;
  logic [10:0] frm_len;
  logic [15:0] good_count_gray, bad_count_gray;

  always #5 clk = ~clk;

  rx_frame_checker dut (
    .clk             (clk),
    .arst_n          (arst_n),
    .fifo_empty      (fifo_empty),
    .fifo_dout       (fifo_dout),
    .fifo_EOD_out    (fifo_EOD_out),
    .fifo_rden       (fifo_rden),
    .m_data          (m_data),
    .m_valid         (m_valid),
    .m_ready         (m_ready),
    .m_last          (m_last),
    .frm_done        (frm_done),
    .frm_ok          (frm_ok),
    .frm_runt        (frm_runt),
    .frm_long        (frm_long),
    .frm_len         (frm_len),
    .good_count_gray (good_count_gray),
    .bad_count_gray  (bad_count_gray)
  );

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] qd[$];
  logic       qe[$];
  logic [7:0] frm[$];
  logic [7:0] rx[$];

  int cyc = 0, last_idx = -1, n_done = 0, pop_cnt = 0;
  int stall_at = -1, stall_cnt = 0, gap_at = -1, gap_cnt = 0;
  int n_hold = 0, last_cyc = 0, gap_meas = 999;
  logic hold_have = 1'b0, gap_pending = 1'b0;
  logic [7:0] hold_data;
  logic s_rden, s_xfer, s_last, s_done, s_ok, s_runt, s_long;
  logic [7:0]  s_data;
  logic [10:0] s_len;
  logic st_ok = 1'b0, st_runt = 1'b0, st_long = 1'b0;
  logic [10:0] st_len = 11'd0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c ^ {24'h0, b};
    for (int k = 0; k < 8; k++) r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
    return r;
  endfunction

  // Payload pattern followed by a correct little-endian FCS
  task automatic make_frame(input int len, input int seed);
    logic [31:0] c;
    logic [7:0]  b;
    frm.delete();
    c = 32'hFFFF_FFFF;
    for (int i = 0; i < len - 4; i++) begin
      b = 8'((i * 13 + seed) & 255);
      frm.push_back(b);
      c = crc_step(c, b);
    end
    c = ~c;
    for (int k = 0; k < 4; k++) frm.push_back(c[8*k +: 8]);
  endtask

  task automatic send_frame();
    rx.delete();
    last_idx = -1;
    pop_cnt  = 0;
    n_hold   = 0;
    foreach (frm[i]) begin
      qd.push_back(frm[i]);
      qe.push_back(i == frm.size() - 1);
    end
  endtask

  task automatic check_frame(input string nm, input int exp_out, input logic e_ok,
                             input logic e_runt, input logic e_long, input int e_len,
                             input logic [15:0] e_good, input logic [15:0] e_bad);
    int base, t, mism;
    base = n_done;
    t = 0;
    while (n_done == base && t < 6000) begin
      @(negedge clk);
      t++;
    end
    repeat (3) @(negedge clk);
    chk({nm, "_done_once"}, n_done, base + 1);
    chk({nm, "_nbytes"}, rx.size(), exp_out);
    mism = 0;
    for (int i = 0; i < rx.size() && i < exp_out; i++) if (rx[i] !== frm[i]) mism++;
    chk({nm, "_data_mism"}, mism, 0);
    chk({nm, "_last_pos"}, last_idx, exp_out - 1);
    chk({nm, "_ok"}, st_ok, e_ok);
    chk({nm, "_runt"}, st_runt, e_runt);
    chk({nm, "_long"}, st_long, e_long);
    chk({nm, "_len"}, st_len, e_len);
    chk({nm, "_good_gray"}, good_count_gray, e_good);
    chk({nm, "_bad_gray"}, bad_count_gray, e_bad);
  endtask

  // FIFO model and sink: sample mid-cycle, act just after the rising edge
  initial begin
    forever begin
      @(negedge clk);
      s_rden = fifo_rden;
      s_xfer = m_valid && m_ready;
      s_data = m_data;
      s_last = m_last;
      s_done = frm_done;
      s_ok   = frm_ok;
      s_runt = frm_runt;
      s_long = frm_long;
      s_len  = frm_len;
      if (fifo_rden) chk("rden_while_empty", fifo_empty, 1'b0);
      if (m_valid && !m_ready) begin
        n_hold++;
        chk("stall_rden", fifo_rden, 1'b0);
        if (hold_have) chk("stall_data_held", m_data, hold_data);
        else begin
          hold_have = 1'b1;
          hold_data = m_data;
        end
      end else begin
        hold_have = 1'b0;
      end
      @(posedge clk);
      #1;
      if (arst_n) begin
        cyc++;
        if (s_rden && qd.size() > 0) begin
          void'(qd.pop_front());
          void'(qe.pop_front());
          pop_cnt++;
          if (gap_pending) begin
            gap_meas    = cyc - last_cyc;
            gap_pending = 1'b0;
          end
        end
        if (s_xfer) begin
          rx.push_back(s_data);
          if (s_last) begin
            last_idx    = rx.size() - 1;
            last_cyc    = cyc;
            gap_pending = 1'b1;
          end
        end
        if (s_done) begin
          n_done++;
          st_ok   = s_ok;
          st_runt = s_runt;
          st_long = s_long;
          st_len  = s_len;
        end
        if (stall_cnt > 0) begin
          stall_cnt--;
          m_ready = 1'b0;
        end else if (stall_at >= 0 && rx.size() == stall_at) begin
          stall_at  = -1;
          stall_cnt = 9;
          m_ready   = 1'b0;
        end else begin
          m_ready = 1'b1;
        end
        if (gap_cnt > 0) gap_cnt--;
        else if (gap_at >= 0 && pop_cnt == gap_at) begin
          gap_at  = -1;
          gap_cnt = 5;
        end
        fifo_empty   = (qd.size() == 0) || (gap_cnt > 0);
        fifo_dout    = (qd.size() > 0) ? qd[0] : 8'h00;
        fifo_EOD_out = (qd.size() > 0) ? qe[0] : 1'b0;
      end
    end
  end

  initial begin
    int base;
    arst_n       = 1'b0;
    fifo_empty   = 1'b1;
    fifo_dout    = 8'h00;
    fifo_EOD_out = 1'b0;
    m_ready      = 1'b1;
    #2;
    chk("rst_m_valid", m_valid, 1'b0);
    chk("rst_m_last", m_last, 1'b0);
    chk("rst_rden", fifo_rden, 1'b0);
    chk("rst_done", frm_done, 1'b0);
    chk("rst_flags", {frm_ok, frm_runt, frm_long}, 3'b000);
    chk("rst_len", frm_len, 11'd0);
    chk("rst_good", good_count_gray, 16'h0000);
    chk("rst_bad", bad_count_gray, 16'h0000);
    repeat (3) @(negedge clk);
    arst_n = 1'b1;

    // Good 64-byte frame with a 5-cycle FIFO underrun mid-frame
    make_frame(64, 5);
    gap_at = 30;
    send_frame();
    check_frame("good64", 60, 1'b1, 1'b0, 1'b0, 64, 16'h0001, 16'h0000);
    chk("fifo_gap_taken", gap_at, -1);

    // Same frame with bit 0 of byte 10 flipped
    make_frame(64, 5);
    frm[10] = frm[10] ^ 8'h01;
    send_frame();
    check_frame("badcrc", 60, 1'b0, 1'b0, 1'b0, 64, 16'h0001, 16'h0001);

    // 3-byte runt
    frm.delete();
    frm.push_back(8'h11);
    frm.push_back(8'h22);
    frm.push_back(8'h33);
    send_frame();
    check_frame("runt3", 0, 1'b0, 1'b1, 1'b0, 3, 16'h0001, 16'h0003);

    // Good frame with m_ready low for 10 cycles after 20 bytes
    make_frame(64, 77);
    stall_at = 20;
    send_frame();
    check_frame("stall", 60, 1'b1, 1'b0, 1'b0, 64, 16'h0003, 16'h0003);
    chk("stall_cycles", n_hold, 10);

    // Oversize frames
    make_frame(2000, 9);
    send_frame();
    check_frame("long2000", 1996, 1'b0, 1'b0, 1'b1, 2000, 16'h0003, 16'h0002);
    make_frame(2100, 1);
    send_frame();
    check_frame("long2100", 2096, 1'b0, 1'b0, 1'b1, 2047, 16'h0003, 16'h0006);

    // Two back-to-back good frames, reset during the second
    make_frame(64, 33);
    gap_pending = 1'b0;
    gap_meas    = 999;
    send_frame();
    send_frame();
    check_frame("b2b_first", 60, 1'b1, 1'b0, 1'b0, 64, 16'h0002, 16'h0006);
    repeat (2) @(negedge clk);
    chk("b2b_gap_le2", gap_meas <= 2, 1'b1);
    repeat (10) @(negedge clk);
    #2;
    arst_n = 1'b0;
    qd.delete();
    qe.delete();
    fifo_empty = 1'b1;
    #1;
    chk("midrst_m_valid", m_valid, 1'b0);
    chk("midrst_rden", fifo_rden, 1'b0);
    chk("midrst_len", frm_len, 11'd0);
    chk("midrst_good", good_count_gray, 16'h0000);
    chk("midrst_bad", bad_count_gray, 16'h0000);
    repeat (3) @(negedge clk);
    arst_n = 1'b1;
    base = n_done;
    repeat (100) @(negedge clk);
    chk("no_done_after_rst", n_done, base);

    // Recovery after reset
    make_frame(64, 200);
    send_frame();
    check_frame("recover", 60, 1'b1, 1'b0, 1'b0, 64, 16'h0001, 16'h0000);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
